// File: rtl/clk_phase_div.sv
// clk_phase_div: NUM_OUT phase-staggered divided clock-enable waves from clk_in1.
// Latency: clk_out (and clk_out_inv when built) is one register stage after the base counter.
// Handshake: cfg_req is held high until cfg_ack, and the change is applied only on a period boundary.
//
// Ports:
//   clk_in1, resetn          fabric clock, asynchronous active-low reset
//   div_val, high_val        requested ratio N and high time H (DIV_W bits each)
//   phase_val                per-output phase P_i, field i at [i*DIV_W +: DIV_W]
//   cfg_req / cfg_ack        request level / one-cycle apply pulse
//   clk_out, clk_out_inv     registered phase outputs and their complement
//   locked                   waveforms stable for LOCK_PERIODS full periods
//
// Build option: define CLK_PHASE_DIV_INV_EN to get a registered clk_out_inv.
// Without it, clk_out_inv is tied to 0.
module clk_phase_div #(
  parameter int NUM_OUT      = 4,
  parameter int DIV_W        = 8,
  parameter int RST_DIV      = 4,
  parameter int RST_HIGH     = 2,
  parameter int LOCK_PERIODS = 16
) (
  input  logic                     clk_in1,
  input  logic                     resetn,
  input  logic [DIV_W-1:0]         div_val,
  input  logic [DIV_W-1:0]         high_val,
  input  logic [NUM_OUT*DIV_W-1:0] phase_val,
  input  logic                     cfg_req,
  output logic                     cfg_ack,
  output logic [NUM_OUT-1:0]       clk_out,
  output logic [NUM_OUT-1:0]       clk_out_inv,
  output logic                     locked
);

  // Reset configuration goes through the same clamping as runtime requests,
  // so an odd parameter choice still yields a legal waveform.
  localparam int RST_N_I = (RST_DIV < 2) ? 2 : RST_DIV;
  localparam int RST_H_I = (RST_HIGH < 1) ? 1 :
                           ((RST_HIGH >= RST_N_I) ? RST_N_I - 1 : RST_HIGH);
  localparam logic [DIV_W-1:0] RST_N = DIV_W'(RST_N_I);
  localparam logic [DIV_W-1:0] RST_H = DIV_W'(RST_H_I);

  localparam int               CNT_W    = $clog2(LOCK_PERIODS + 1);
  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_PERIODS);

  typedef struct packed {
    logic [NUM_OUT-1:0][DIV_W-1:0] p;
    logic [DIV_W-1:0]              h;
    logic [DIV_W-1:0]              n;
  } cfg_t;

  typedef enum logic [0:0] {
    WARM = 1'b0,
    LOCK = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  cfg_t               cfg_q;
  logic [DIV_W-1:0]   cnt_q;
  logic               pend_q;
  logic [NUM_OUT-1:0] out_q;
  state_t             state_q;
  logic [CNT_W-1:0]   per_q;

  cfg_t               cfg_san;
  cfg_t               cfg_eff;
  logic [DIV_W-1:0]   cnt_d;
  logic               pend_d;
  logic [NUM_OUT-1:0] out_d;
  state_t             state_d;
  logic [CNT_W-1:0]   per_d;

  logic boundary;
  logic apply;
  logic period_end;
  logic n_change;

  // ---------------------------------------------------------------------------
  // Request sanitising: the requested values are clamped into a legal
  // waveform (N >= 2, 1 <= H <= N-1, P_i <= N-1) before they can be latched.
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg_san = '0;
    cfg_san.n = (div_val < DIV_W'(2)) ? DIV_W'(2) : div_val;

    if (high_val == '0) begin
      cfg_san.h = DIV_W'(1);
    end else if (high_val >= cfg_san.n) begin
      cfg_san.h = cfg_san.n - DIV_W'(1);
    end else begin
      cfg_san.h = high_val;
    end

    for (int i = 0; i < NUM_OUT; i++) begin
      if (phase_val[i*DIV_W +: DIV_W] >= cfg_san.n) begin
        cfg_san.p[i] = cfg_san.n - DIV_W'(1);
      end else begin
        cfg_san.p[i] = phase_val[i*DIV_W +: DIV_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake. A request is remembered in pend_q and only takes effect in a
  // cycle where the counter sits at 0, so a waveform is never cut mid-period.
  // The request level is ignored during the ack cycle itself, so a requester
  // that drops cfg_req after seeing ack produces exactly one application.
  // ---------------------------------------------------------------------------
  assign boundary = (cnt_q == '0);
  assign apply    = pend_q & boundary;
  assign cfg_ack  = apply;

  assign pend_d   = apply ? 1'b0 : (pend_q | cfg_req);

  // The configuration used this cycle. On an apply cycle the new values
  // already drive the output compare, so the registered outputs show the new
  // waveform in the cycle right after cfg_ack.
  assign cfg_eff  = apply ? cfg_san : cfg_q;

  assign period_end = (cnt_q >= cfg_q.n - DIV_W'(1));
  assign n_change   = (cfg_san.n != cfg_q.n);

  // ---------------------------------------------------------------------------
  // Base counter and output compare.
  // Output i is high while (c - P_i) mod N < H. Because c and P_i are both
  // below N, the modulo reduces to a single conditional add of N; one extra
  // bit keeps c + N from wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = (cnt_q >= cfg_eff.n - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);

    out_d = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (cnt_q >= cfg_eff.p[i]) begin
        out_d[i] = ((cnt_q - cfg_eff.p[i]) < cfg_eff.h);
      end else begin
        out_d[i] = (({1'b0, cnt_q} + {1'b0, cfg_eff.n} - {1'b0, cfg_eff.p[i]})
                    < {1'b0, cfg_eff.h});
      end
    end
  end

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      cfg_q.n <= RST_N;
      cfg_q.h <= RST_H;
      cfg_q.p <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      cfg_q   <= cfg_eff;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
    end
  end

  assign clk_out = out_q;

  // ---------------------------------------------------------------------------
  // Lock FSM.
  // per_q counts completed periods (incremented on the last cycle of each
  // period). The WARM -> LOCK step is taken on the boundary that follows the
  // LOCK_PERIODS-th completion, so locked rises one cycle after that boundary.
  // A change of N restarts the warm-up; H/P-only changes leave lock alone.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    per_d   = per_q;

    case (state_q)
      WARM: begin
        if (period_end && (per_q != LOCK_CNT)) begin
          per_d = per_q + CNT_W'(1);
        end
        if (boundary && (per_q == LOCK_CNT)) begin
          state_d = LOCK;
        end
      end
      LOCK: begin
        state_d = LOCK;
      end
      default: begin
        state_d = WARM;
        per_d   = '0;
      end
    endcase

    if (apply && n_change) begin
      state_d = WARM;
      per_d   = '0;
    end
  end

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      state_q <= WARM;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
    end
  end

  assign locked = (state_q == LOCK);

  // ---------------------------------------------------------------------------
  // Inverted outputs: a parallel register fed from the same compare so both
  // copies switch on the same edge.
  // ---------------------------------------------------------------------------
`ifdef CLK_PHASE_DIV_INV_EN
  logic [NUM_OUT-1:0] inv_q;

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      inv_q <= '1;
    end else begin
      inv_q <= ~out_d;
    end
  end

  assign clk_out_inv = inv_q;
`else
  assign clk_out_inv = '0;
`endif

endmodule

// File: tb/tb_clk_phase_div.sv
module tb_clk_phase_div;

  localparam int NUM_OUT = 4;
  localparam int DIV_W   = 8;

  localparam int K_OUT  = 0;
  localparam int K_INV  = 1;
  localparam int K_LOCK = 2;
  localparam int K_ACK  = 3;

  logic                     clk_in1 = 1'b0;
  logic                     resetn;
  logic [DIV_W-1:0]         div_val;
  logic [DIV_W-1:0]         high_val;
  logic [NUM_OUT*DIV_W-1:0] phase_val;
  logic                     cfg_req;
  logic                     cfg_ack;
  logic [NUM_OUT-1:0]       clk_out;
  logic [NUM_OUT-1:0]       clk_out_inv;
  logic                     locked;

  clk_phase_div #(
    .NUM_OUT      (NUM_OUT),
    .DIV_W        (DIV_W),
    .RST_DIV      (4),
    .RST_HIGH     (2),
    .LOCK_PERIODS (16)
  ) dut (
    .clk_in1     (clk_in1),
    .resetn      (resetn),
    .div_val     (div_val),
    .high_val    (high_val),
    .phase_val   (phase_val),
    .cfg_req     (cfg_req),
    .cfg_ack     (cfg_ack),
    .clk_out     (clk_out),
    .clk_out_inv (clk_out_inv),
    .locked      (locked)
  );

  always #5 clk_in1 = ~clk_in1;

  int cyc = 0;
  always @(posedge clk_in1) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   base = 0;
  bit   done = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  // Hand-derived clk_out words ({o3,o2,o1,o0}) indexed by counter value.
  logic [3:0] tab_h2 [4] = '{4'hF, 4'hF, 4'h0, 4'h0};  // N=4 H=2 P=0
  logic [3:0] tab_h3 [4] = '{4'hF, 4'hF, 4'hF, 4'h0};  // N=4 H=3 P=0
  logic [3:0] tab8   [8] = '{4'h9, 4'h9, 4'h3, 4'h3, 4'h6, 4'h6, 4'hC, 4'hC}; // N=8 H=4 P={0,2,4,6}
  logic [3:0] tab2   [2] = '{4'h7, 4'h8};                // N=2 H=1 P={0,0,0,1}

  function automatic void push_exp(input int k, input int kind, input logic [31:0] v);
    exp_t e;
    e.cyc  = base + k;
    e.kind = kind;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  function automatic void push_cyc(input int k, input logic [3:0] o, input logic l, input logic a);
    logic [3:0] inv;
`ifdef CLK_PHASE_DIV_INV_EN
    inv = ~o;
`else
    inv = 4'h0;
`endif
    push_exp(k, K_OUT, {28'h0, o});
    push_exp(k, K_INV, {28'h0, inv});
    push_exp(k, K_LOCK, {31'h0, l});
    push_exp(k, K_ACK, {31'h0, a});
  endfunction

  function automatic string kind_name(input int kind);
    case (kind)
      K_OUT:   return "clk_out";
      K_INV:   return "clk_out_inv";
      K_LOCK:  return "locked";
      default: return "cfg_ack";
    endcase
  endfunction

  task automatic to_k(input int k);
    int guard;
    guard = 0;
    while ((cyc - base) < k) begin
      @(negedge clk_in1);
      guard++;
      if (guard > 5000) begin
        $display("FAIL to_k wait expired at cycle %0d waiting for %0d", cyc - base, k);
        $fatal(1, "wait bound expired");
      end
    end
  endtask

  // Monitor: on every falling edge, compare all expectations due this cycle.
  initial begin
    logic [31:0] act;
    forever begin
      @(negedge clk_in1);
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if ((exp_q[i].cyc <= cyc) || done) begin
          n_cmp++;
          if (exp_q[i].cyc != cyc) begin
            n_fail++;
            $display("FAIL %s expectation for cycle %0d not sampled (now %0d), required %0h",
                     kind_name(exp_q[i].kind), exp_q[i].cyc, cyc, exp_q[i].val);
          end else begin
            case (exp_q[i].kind)
              K_OUT:   act = {28'h0, clk_out};
              K_INV:   act = {28'h0, clk_out_inv};
              K_LOCK:  act = {31'h0, locked};
              default: act = {31'h0, cfg_ack};
            endcase
            if (act !== exp_q[i].val) begin
              n_fail++;
              $display("FAIL %s at cycle %0d (rel %0d): got %0h required %0h",
                       kind_name(exp_q[i].kind), cyc, cyc - base, act, exp_q[i].val);
            end
          end
          exp_q.delete(i);
        end
      end
    end
  end

  // Stimulus
  initial begin
    resetn    = 1'b0;
    div_val   = 8'd4;
    high_val  = 8'd2;
    phase_val = '0;
    cfg_req   = 1'b0;
    repeat (3) @(posedge clk_in1);
    #2;

    // Reset defaults: 1100 on all outputs, locked at cycle 65.
    base = cyc;
    for (int k = 0; k < 80; k++)
      push_cyc(k, (k == 0) ? 4'h0 : tab_h2[(k - 1) % 4], (k >= 65), 1'b0);
    resetn = 1'b1;

    // H-only change 2->3, request rising on boundary cycle 80 -> ack at 84.
    to_k(79);
    for (int k = 80; k < 100; k++)
      push_cyc(k, (k <= 84) ? tab_h2[(k - 1) % 4] : tab_h3[(k - 1) % 4], 1'b1, (k == 84));
    to_k(80);
    cfg_req  = 1'b1;
    high_val = 8'd3;
    to_k(85);
    cfg_req  = 1'b0;

    // Phase stagger N=8 H=4 P={0,2,4,6}: ack at 104, relock at 233.
    to_k(99);
    for (int k = 100; k < 240; k++)
      push_cyc(k, (k <= 104) ? tab_h3[(k - 1) % 4] : tab8[(k - 105) % 8],
               (k <= 104) || (k >= 233), (k == 104));
    to_k(101);
    cfg_req   = 1'b1;
    div_val   = 8'd8;
    high_val  = 8'd4;
    phase_val = {8'd6, 8'd4, 8'd2, 8'd0};
    to_k(105);
    cfg_req   = 1'b0;

    // Held request over three periods: acks only on boundaries 248/256/264.
    to_k(239);
    for (int k = 240; k < 280; k++)
      push_cyc(k, tab8[(k - 105) % 8], 1'b1, (k == 248) || (k == 256) || (k == 264));
    to_k(241);
    cfg_req = 1'b1;
    to_k(265);
    cfg_req = 1'b0;

    // Sanitising N=1 H=0 P3=200 -> N=2 H=1 P3=1: ack at 288, relock at 321.
    to_k(279);
    for (int k = 280; k < 330; k++)
      push_cyc(k, (k <= 288) ? tab8[(k - 105) % 8] : tab2[(k - 289) % 2],
               (k <= 288) || (k >= 321), (k == 288));
    to_k(281);
    cfg_req   = 1'b1;
    div_val   = 8'd1;
    high_val  = 8'd0;
    phase_val = {8'd200, 8'd0, 8'd0, 8'd0};
    to_k(289);
    cfg_req   = 1'b0;

    // Mid-period reset with a request pending.
    to_k(329);
    push_cyc(330, tab2[(330 - 289) % 2], 1'b1, 1'b0);
    for (int k = 331; k < 334; k++)
      push_cyc(k, 4'h0, 1'b0, 1'b0);
    to_k(330);
    cfg_req   = 1'b1;
    div_val   = 8'd6;
    high_val  = 8'd1;
    phase_val = '0;
    @(posedge clk_in1);
    #2;
    resetn  = 1'b0;
    cfg_req = 1'b0;
    repeat (3) @(posedge clk_in1);
    #2;

    // After release: defaults again, no leftover ack from the discarded request.
    base = cyc;
    for (int k = 0; k < 40; k++)
      push_cyc(k, (k == 0) ? 4'h0 : tab_h2[(k - 1) % 4], 1'b0, 1'b0);
    resetn = 1'b1;
    to_k(40);

    done = 1'b1;
    repeat (3) @(negedge clk_in1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
